// File: rtl/xcorr_peak_detect.sv
// Cross-correlation peak detector.
// Takes the complex IFFT correlation stream and finds the largest |I|+|Q|
// sample in each frame. For every frame it reports that peak, the index of
// the peak, the frame's block exponent, a threshold detection flag and a
// frame-length error flag. The block is a two-stage pipeline: stage 1
// registers the magnitude, and stage 2 does the compare/accumulate and
// writes the report.
module xcorr_peak_detect #(
  parameter int FRAME_LEN = 1024,
  parameter int IDX_W     = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ival,
  input  logic signed [15:0] idata_i,
  input  logic signed [15:0] idata_q,
  input  logic [4:0]         iexp,
  input  logic               ieop,
  input  logic [31:0]        ithr,
  output logic               oval,
  output logic [16:0]        opeak,
  output logic [IDX_W-1:0]   oidx,
  output logic [4:0]         oexp,
  output logic               odet,
  output logic               oerr
);

  // state | meaning
  // IDLE  | no frame open; the next valid sample starts a frame
  // ACC   | frame open; tracking max, its index and the sample count
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACC  = 1'b1;

  localparam logic [IDX_W:0] FRAME_LEN_C = FRAME_LEN[IDX_W:0];

  logic [16:0]      w_abs_i;
  logic [16:0]      w_abs_q;
  logic [16:0]      w_mag;

  logic             r_s1_val;
  logic             r_s1_eop;
  logic [16:0]      r_s1_mag;
  logic [4:0]       r_s1_exp;

  logic [0:0]       r_state;
  logic [16:0]      r_max;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_cnt;
  logic [4:0]       r_exp;

  logic             w_first;
  logic             w_gt;
  logic [16:0]      w_cand_max;
  logic [IDX_W-1:0] w_cand_idx;
  logic [IDX_W:0]   w_cnt_next;
  logic [4:0]       w_cand_exp;
  logic             w_full;
  logic             w_close;
  logic             w_err;
  logic [47:0]      w_shifted;
  logic             w_det;

  logic             r_oval;
  logic [16:0]      r_opeak;
  logic [IDX_W-1:0] r_oidx;
  logic [4:0]       r_oexp;
  logic             r_odet;
  logic             r_oerr;

  // |x| is taken in 17 bits, so -32768 becomes +32768 with no saturation.
  assign w_abs_i = idata_i[15] ? (17'd0 - {idata_i[15], idata_i}) : {1'b0, idata_i};
  assign w_abs_q = idata_q[15] ? (17'd0 - {idata_q[15], idata_q}) : {1'b0, idata_q};
  assign w_mag   = w_abs_i + w_abs_q;

  // Stage 1: register the magnitude and the sample qualifiers. An eop without
  // ival is dropped here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_val <= 1'b0;
      r_s1_eop <= 1'b0;
      r_s1_mag <= '0;
      r_s1_exp <= '0;
    end else begin
      r_s1_val <= ival;
      r_s1_eop <= ival & ieop;
      r_s1_mag <= w_mag;
      r_s1_exp <= iexp;
    end
  end

  // Stage 2 candidate values. A sample arriving in IDLE is treated as index 0
  // and always wins the compare. Because the compare is strict, a tie keeps
  // the earlier index.
  assign w_first    = (r_state == ST_IDLE);
  assign w_gt       = w_first | (r_s1_mag > r_max);
  assign w_cand_max = w_gt ? r_s1_mag : r_max;
  assign w_cand_idx = w_first ? '0 : (w_gt ? r_cnt : r_idx);
  assign w_cnt_next = w_first ? {{IDX_W{1'b0}}, 1'b1} : ({1'b0, r_cnt} + 1'b1);
  assign w_cand_exp = w_first ? r_s1_exp : r_exp;
  assign w_full     = (w_cnt_next == FRAME_LEN_C);
  assign w_close    = r_s1_val & (r_s1_eop | w_full);
  assign w_err      = ~(r_s1_eop & w_full);
  assign w_shifted  = {31'b0, w_cand_max} << w_cand_exp;
  assign w_det      = (w_shifted >= {16'b0, ithr});

  // Stage 2 frame accumulator. Closing a frame clears everything, so the next
  // valid sample (even on the very next cycle) opens a fresh frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_max   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_exp   <= '0;
    end else if (r_s1_val) begin
      if (w_close) begin
        r_state <= ST_IDLE;
        r_max   <= '0;
        r_idx   <= '0;
        r_cnt   <= '0;
        r_exp   <= '0;
      end else begin
        r_state <= ST_ACC;
        r_max   <= w_cand_max;
        r_idx   <= w_cand_idx;
        r_cnt   <= w_cnt_next[IDX_W-1:0];
        r_exp   <= w_cand_exp;
      end
    end
  end

  // Report registers: a one-cycle strobe, and the fields hold until the next
  // close.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_oval  <= 1'b0;
      r_opeak <= '0;
      r_oidx  <= '0;
      r_oexp  <= '0;
      r_odet  <= 1'b0;
      r_oerr  <= 1'b0;
    end else begin
      r_oval <= w_close;
      if (w_close) begin
        r_opeak <= w_cand_max;
        r_oidx  <= w_cand_idx;
        r_oexp  <= w_cand_exp;
        r_odet  <= w_det;
        r_oerr  <= w_err;
      end
    end
  end

  assign oval  = r_oval;
  assign opeak = r_opeak;
  assign oidx  = r_oidx;
  assign oexp  = r_oexp;
  assign odet  = r_odet;
  assign oerr  = r_oerr;

endmodule

// File: doc/xcorr_peak_detect.md
XCORR_PEAK_DETECT -- requirements
Module: xcorr_peak_detect

Interface
REQ-001 Parameter FRAME_LEN, default 1024, nominal samples per correlation frame (power of two, 16..65536).
REQ-002 Parameter IDX_W, default 10, index width, equal to log2(FRAME_LEN).
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 ival  input  1  input sample valid; no backpressure, gaps allowed.
REQ-006 idata_i  input  16  signed real part of the IFFT correlation output.
REQ-007 idata_q  input  16  signed imaginary part of the IFFT correlation output.
REQ-008 iexp  input  5  block exponent of the current frame.
REQ-009 ieop  input  1  last sample of frame; qualified by ival.
REQ-010 ithr  input  32  unsigned detection threshold in exponent-aligned units; sampled at report time.
REQ-011 oval  output  1  one-cycle report strobe per frame.
REQ-012 opeak  output  17  unsigned peak magnitude of the frame, unscaled.
REQ-013 oidx  output  IDX_W  sample index of the peak within the frame.
REQ-014 oexp  output  5  exponent latched for the reported frame.
REQ-015 odet  output  1  detection flag; peak aligned by exponent is >= ithr.
REQ-016 oerr  output  1  frame-length error flag, valid with oval.

Function
REQ-017 Magnitude SHALL be computed as mag = |idata_i| + |idata_q|, 17-bit unsigned; |-32768| = 32768, with no saturation.
REQ-018 Stage 1 SHALL register mag, ival, ieop and iexp; stage 2 SHALL perform compare and accumulate.
REQ-019 FSM states SHALL be IDLE (no frame open) and ACC (frame open).
REQ-020 IDLE -> ACC on a stage-1 valid sample without eop.
REQ-021 On the first sample: max <= mag, idx <= 0, cnt <= 1, and exponent latched from that sample.
REQ-022 In ACC, on each valid sample: if mag > max (strictly), then max <= mag and idx <= cnt; cnt increments.
REQ-023 Ties SHALL keep the earliest index.
REQ-024 A valid sample with eop SHALL close the frame, including itself in the compare, and return to IDLE.
REQ-025 A frame of one sample (eop on the first sample) SHALL be reported with idx 0 and SHALL NOT enter ACC.
REQ-026 ieop without ival SHALL be ignored.
REQ-027 Changes of iexp mid-frame SHALL be ignored; the exponent latched on the first sample is reported.
REQ-028 If cnt reaches FRAME_LEN with no eop, the frame SHALL close as if eop were present, with oerr=1.
REQ-029 The next valid sample after a forced close SHALL open a new frame.
REQ-030 A frame closed by eop with total samples != FRAME_LEN SHALL report oerr=1; otherwise oerr=0.
REQ-031 Report: oval SHALL pulse for exactly 1 cycle, 2 cycles after the eop sample is presented at input (latency 2).
REQ-032 opeak, oidx, oexp, odet and oerr SHALL be registered and SHALL hold until the next report.
REQ-033 odet SHALL be 1 when ({31'b0, peak} << exp) >= {16'b0, ithr}, using a 48-bit compare with no truncation.
REQ-034 Back-to-back frames (first sample of frame N+1 on the cycle after eop of frame N) SHALL be accepted with no lost sample and no corrupted report.
REQ-035 The block SHALL hold no state across frames other than the report registers.

Reset
REQ-036 While rst=1: FSM at IDLE; pipeline valid, max, idx and cnt cleared.
REQ-037 While rst=1: oval, odet and oerr at 0; opeak, oidx and oexp at 0.
REQ-038 Reset mid-frame SHALL discard the partial frame with no report; the first valid sample after reset starts a new frame.
REQ-039 Inputs arriving during reset SHALL be ignored.

Verification
REQ-040 FRAME_LEN=16, one sample (i=300, q=-400) at index 5, all others 0, iexp=2, ithr=2800 -> one oval 2 cycles after eop with opeak=700, oidx=5, oexp=2, odet=1, oerr=0.
REQ-041 Same frame with ithr=2801 -> odet=0, other fields unchanged.
REQ-042 Equal peak 1000 at indices 3 and 9, with ival toggling 1010... -> oidx=3, one oval.
REQ-043 Two back-to-back frames with peaks at indices 2 and 14 -> two oval pulses 16 cycles apart, oidx 2 then 14.
REQ-044 Frame of 20 valid samples with no ieop -> report after sample 16 with oerr=1; samples 17..20 open a new frame.
REQ-045 rst asserted after 8 samples of a frame, then a full frame sent -> exactly one report, for the second frame only; outputs 0 during reset.
